fhe_fu_scheduler: RTL

- Round-robin scheduler that shares one external 8-bit two-operand combinational function unit (FU) among NREQ requesters.
- The FU is one of the team's synthesized 16-input/8-output arithmetic netlists. Its operand bits map to x0..x15 and its result bits come from y0..y7.
- The block arbitrates requests, captures and holds the FU operands for a fixed settle time, then samples the result and returns it to the winner over a valid/ready response channel.

---
 rtl/fhe_fu_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fhe_fu_scheduler.sv
// fhe_fu_scheduler: round-robin sharing of one combinational 8-bit FU.
// Optional counters: define FHE_FU_STATS_EN for ops_done/busy_cycles.
module fhe_fu_scheduler #(
    parameter int NREQ   = 4,
    parameter int W      = 8,
    parameter int FU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [W-1:0]      fu_a,
    output logic [W-1:0]      fu_b,
    input  logic [W-1:0]      fu_y,
    output logic              busy
`ifdef FHE_FU_STATS_EN
    ,
    output logic [15:0]       ops_done,
    output logic [15:0]       busy_cycles
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] win;
    logic          win_vld;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic          acc_hs;
    logic          rsp_hs;

    // First valid requester scanning upward from ptr, wrapping at NREQ
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                win_vld = 1'b1;
                win     = IW'(idx);
            end
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        acc_hs    = 1'b0;
        rsp_hs    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    req_ready[win] = 1'b1;
                    acc_hs         = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, settle countdown, result sample and pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            if (acc_hs) begin
                a_q     <= req_a[int'(win)*W +: W];
                b_q     <= req_b[int'(win)*W +: W];
                owner_q <= win;
                cnt_q   <= CW'(FU_LAT - 1);
            end
            if (state_q == EXEC) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    res_q <= fu_y;
                end
            end
            if (rsp_hs) begin
                if (owner_q == IW'(NREQ - 1)) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= owner_q + 1'b1;
                end
            end
        end
    end

    assign fu_a     = a_q;
    assign fu_b     = b_q;
    assign rsp_data = res_q;
    assign busy     = (state_q != IDLE);

`ifdef FHE_FU_STATS_EN
    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done    <= '0;
            busy_cycles <= '0;
        end else begin
            if (rsp_hs && ops_done != 16'hFFFF) begin
                ops_done <= ops_done + 16'd1;
            end
            if (busy && busy_cycles != 16'hFFFF) begin
                busy_cycles <= busy_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
